// File: rtl/imem_pkg.sv
// Shared types and helpers for the loadable instruction memory.
package imem_pkg;

  // Fetch/load mode of the memory.
  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_LOAD = 1'b1
  } imem_state_e;

  // MIPS nop (sll $0,$0,0), returned on bubbles and faults.
  localparam logic [31:0] NOP_WORD = 32'h0000_0000;

  // Ceiling log2, used for word-address widths.
  function automatic int clog2(input int value);
    int result;
    result = 0;
    while ((1 << result) < value) begin
      result = result + 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/imem_ram.sv
// Simple dual-port synchronous RAM: one write port, one registered read port.
// Writes only occur in LOAD and reads only in RUN, so read/write collision
// behaviour is irrelevant.
module imem_ram #(
  parameter int DEPTH     = 256,
  parameter int DATA_W    = 32,
  parameter int AW        = 8,
  parameter     INIT_FILE = ""
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic [AW-1:0]     waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic              re_i,
  input  logic [AW-1:0]     raddr_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rdata_q;

  // Write port and registered read port; read data holds while re_i is low.
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
    if (re_i) begin
      rdata_q <= mem_q[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/imem_loadable.sv
// Instruction memory with run-time load port. In RUN it serves fetches with
// one cycle of latency and flags misaligned/out-of-range addresses; in LOAD it
// accepts image writes and tracks a word count and XOR checksum.
//
// Handshake: there is no backpressure on either port. A fetch is taken on any
// rising edge where fetch_req=1, fetch_stall=0 and the block is (and stays)
// in RUN; its result appears the following cycle. A load write is taken on any
// edge where load_we=1 while in LOAD.
module imem_loadable
  import imem_pkg::*;
#(
  parameter int          DEPTH     = 256,
  parameter int          DATA_W    = 32,
  parameter logic [DATA_W-1:0] FILL_WORD = NOP_WORD[DATA_W-1:0],
  parameter bit          BOOT_RUN  = 1'b1,
  parameter              INIT_FILE = ""
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      fetch_req,
  input  logic [31:0]               fetch_addr,
  input  logic                      fetch_stall,
  output logic [DATA_W-1:0]         instruction,
  output logic                      inst_valid,
  output logic                      inst_fault,
  input  logic                      load_start,
  input  logic                      load_we,
  input  logic [clog2(DEPTH)-1:0]   load_addr,
  input  logic [DATA_W-1:0]         load_data,
  input  logic                      load_commit,
  output logic                      load_busy,
  output logic [clog2(DEPTH):0]     load_count,
  output logic [DATA_W-1:0]         load_sum,
  output logic                      dbg_state_o
);

  localparam int AW = clog2(DEPTH);
  localparam logic [AW:0] COUNT_MAX = {1'b1, {AW{1'b0}}};
  localparam imem_state_e RESET_STATE = BOOT_RUN ? ST_RUN : ST_LOAD;

  imem_state_e       state_q, state_d;
  logic              valid_q, valid_d;
  logic              fault_q, fault_d;
  logic [AW:0]       count_q, count_d;
  logic [DATA_W-1:0] sum_q, sum_d;

  logic [AW-1:0]     fetch_idx;
  logic              fetch_fault;
  logic              fetch_en;
  logic              ram_we;
  logic              ram_re;
  logic [DATA_W-1:0] ram_rdata;

  // Fault decode: byte address must be word aligned and inside the array.
  assign fetch_idx   = fetch_addr[AW+1:2];
  assign fetch_fault = (|fetch_addr[1:0]) | (|fetch_addr[31:AW+2]);

  // A fetch only counts when the block is in RUN before and after this edge.
  assign fetch_en = (state_q == ST_RUN) && (state_d == ST_RUN) &&
                    !fetch_stall && fetch_req;
  assign ram_re   = fetch_en && !fetch_fault;
  assign ram_we   = (state_q == ST_LOAD) && load_we;

  imem_ram #(
    .DEPTH     (DEPTH),
    .DATA_W    (DATA_W),
    .AW        (AW),
    .INIT_FILE (INIT_FILE)
  ) u_ram (
    .clk     (clk),
    .we_i    (ram_we),
    .waddr_i (load_addr),
    .wdata_i (load_data),
    .re_i    (ram_re),
    .raddr_i (fetch_idx),
    .rdata_o (ram_rdata)
  );

  // Mode FSM: load_start has priority over load_commit.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RUN:  if (load_start) state_d = ST_LOAD;
      ST_LOAD: if (load_start) state_d = ST_LOAD;
               else if (load_commit) state_d = ST_RUN;
      default: state_d = RESET_STATE;
    endcase
  end

  // Fetch status: cleared around LOAD, held under stall, else follows the request.
  always_comb begin
    valid_d = valid_q;
    fault_d = fault_q;
    if (state_q == ST_LOAD || state_d == ST_LOAD) begin
      valid_d = 1'b0;
      fault_d = 1'b0;
    end else if (!fetch_stall) begin
      valid_d = fetch_req;
      fault_d = fetch_req & fetch_fault;
    end
  end

  // Load statistics: load_start clears, then this cycle's write is accounted.
  always_comb begin
    count_d = count_q;
    sum_d   = sum_q;
    if (load_start) begin
      count_d = '0;
      sum_d   = '0;
    end
    if (ram_we) begin
      if (count_d != COUNT_MAX) count_d = count_d + 1'b1;
      sum_d = sum_d ^ load_data;
    end
  end

  // State, fetch status and load statistics registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= RESET_STATE;
      valid_q <= 1'b0;
      fault_q <= 1'b0;
      count_q <= '0;
      sum_q   <= '0;
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
      fault_q <= fault_d;
      count_q <= count_d;
      sum_q   <= sum_d;
    end
  end

  // RAM read data holds during stall, so only valid non-faulting slots expose it.
  assign instruction = (valid_q && !fault_q) ? ram_rdata : FILL_WORD;
  assign inst_valid  = valid_q;
  assign inst_fault  = fault_q;
  assign load_busy   = (state_q == ST_LOAD);
  assign load_count  = count_q;
  assign load_sum    = sum_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_imem_loadable.sv
// Directed bench for imem_loadable (DEPTH=256, BOOT_RUN=1, no init file).
module tb_imem_loadable;

  localparam int DEPTH  = 256;
  localparam int DATA_W = 32;
  localparam int AW     = 8;

  logic              clk;
  logic              reset;
  logic              fetch_req;
  logic [31:0]       fetch_addr;
  logic              fetch_stall;
  logic [DATA_W-1:0] instruction;
  logic              inst_valid;
  logic              inst_fault;
  logic              load_start;
  logic              load_we;
  logic [AW-1:0]     load_addr;
  logic [DATA_W-1:0] load_data;
  logic              load_commit;
  logic              load_busy;
  logic [AW:0]       load_count;
  logic [DATA_W-1:0] load_sum;
  logic              dbg_state_o;

  int n_checks;
  int n_fail;

  imem_loadable #(
    .DEPTH     (DEPTH),
    .DATA_W    (DATA_W),
    .FILL_WORD (32'h0000_0000),
    .BOOT_RUN  (1'b1),
    .INIT_FILE ("")
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .fetch_req   (fetch_req),
    .fetch_addr  (fetch_addr),
    .fetch_stall (fetch_stall),
    .instruction (instruction),
    .inst_valid  (inst_valid),
    .inst_fault  (inst_fault),
    .load_start  (load_start),
    .load_we     (load_we),
    .load_addr   (load_addr),
    .load_data   (load_data),
    .load_commit (load_commit),
    .load_busy   (load_busy),
    .load_count  (load_count),
    .load_sum    (load_sum),
    .dbg_state_o (dbg_state_o)
  );

  // Clock and reset defaults
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge, then settle 1ns before driving/sampling.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    fetch_req = 0; fetch_stall = 0; load_start = 0; load_we = 0;
    load_commit = 0; fetch_addr = '0; load_addr = '0; load_data = '0;
  endtask

  // Driver tasks
  task automatic do_fetch(input logic [31:0] addr);
    idle(); fetch_req = 1; fetch_addr = addr;
    tick();
    idle();
  endtask

  task automatic do_write(input logic [AW-1:0] a, input logic [31:0] d, input logic commit);
    idle(); load_we = 1; load_addr = a; load_data = d; load_commit = commit;
    tick();
    idle();
  endtask

  task automatic do_start();
    idle(); load_start = 1;
    tick();
    idle();
  endtask

  task automatic test_reset();
    idle(); reset = 0;
    tick();
    n_checks++; if (instruction !== 32'h0) begin n_fail++; $display("FAIL reset_instr: got %h want 00000000", instruction); end
    n_checks++; if (inst_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", inst_valid); end
    n_checks++; if (inst_fault !== 1'b0) begin n_fail++; $display("FAIL reset_fault: got %b want 0", inst_fault); end
    n_checks++; if (load_count !== 9'd0) begin n_fail++; $display("FAIL reset_count: got %0d want 0", load_count); end
    n_checks++; if (load_sum !== 32'h0) begin n_fail++; $display("FAIL reset_sum: got %h want 0", load_sum); end
    n_checks++; if (load_busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", load_busy); end
    reset = 1;
    tick();
  endtask

  task automatic test_boot_image();
    do_start();
    n_checks++; if (load_busy !== 1'b1) begin n_fail++; $display("FAIL boot_busy: got %b want 1", load_busy); end
    do_write(8'd0, 32'h0800_0003, 1'b1);
    n_checks++; if (load_busy !== 1'b0) begin n_fail++; $display("FAIL boot_commit_busy: got %b want 0", load_busy); end
    do_fetch(32'h0);
    n_checks++; if (instruction !== 32'h0800_0003) begin n_fail++; $display("FAIL boot_fetch0: got %h want 08000003", instruction); end
    n_checks++; if (inst_valid !== 1'b1 || inst_fault !== 1'b0) begin n_fail++; $display("FAIL boot_fetch0_flags: got v=%b f=%b want v=1 f=0", inst_valid, inst_fault); end
  endtask

  task automatic test_fault();
    do_fetch(32'h0000_0006);
    n_checks++; if (inst_fault !== 1'b1 || inst_valid !== 1'b1) begin n_fail++; $display("FAIL misalign_flags: got v=%b f=%b want v=1 f=1", inst_valid, inst_fault); end
    n_checks++; if (instruction !== 32'h0) begin n_fail++; $display("FAIL misalign_instr: got %h want 00000000", instruction); end
    do_fetch(32'h0000_0400);
    n_checks++; if (inst_fault !== 1'b1) begin n_fail++; $display("FAIL oob_fault: got %b want 1", inst_fault); end
    n_checks++; if (instruction !== 32'h0) begin n_fail++; $display("FAIL oob_instr: got %h want 00000000", instruction); end
    do_fetch(32'h8000_0000);
    n_checks++; if (inst_fault !== 1'b1) begin n_fail++; $display("FAIL oob_high_fault: got %b want 1", inst_fault); end
    do_fetch(32'h0);
    n_checks++; if (inst_fault !== 1'b0 || instruction !== 32'h0800_0003) begin n_fail++; $display("FAIL fault_clear: got f=%b %h want f=0 08000003", inst_fault, instruction); end
  endtask

  task automatic test_bubble();
    idle();
    tick();
    n_checks++; if (inst_valid !== 1'b0 || inst_fault !== 1'b0 || instruction !== 32'h0) begin n_fail++; $display("FAIL bubble: got v=%b f=%b %h want v=0 f=0 00000000", inst_valid, inst_fault, instruction); end
  endtask

  task automatic test_load();
    do_start();
    n_checks++; if (load_count !== 9'd0 || load_sum !== 32'h0) begin n_fail++; $display("FAIL load_clear: got %0d %h want 0 0", load_count, load_sum); end
    n_checks++; if (inst_valid !== 1'b0) begin n_fail++; $display("FAIL load_valid: got %b want 0", inst_valid); end
    do_write(8'd0, 32'h201c_0000, 1'b0);
    n_checks++; if (load_count !== 9'd1) begin n_fail++; $display("FAIL load_count1: got %0d want 1", load_count); end
    do_write(8'd1, 32'h2008_0040, 1'b1);
    n_checks++; if (load_count !== 9'd2) begin n_fail++; $display("FAIL load_count2: got %0d want 2", load_count); end
    // 201c0000 ^ 20080040 = 00140040
    n_checks++; if (load_sum !== 32'h0014_0040) begin n_fail++; $display("FAIL load_sum: got %h want 00140040", load_sum); end
    do_fetch(32'h4);
    n_checks++; if (instruction !== 32'h2008_0040) begin n_fail++; $display("FAIL load_fetch4: got %h want 20080040", instruction); end
    do_fetch(32'h0);
    n_checks++; if (instruction !== 32'h201c_0000) begin n_fail++; $display("FAIL load_fetch0: got %h want 201c0000", instruction); end
  endtask

  task automatic test_run_write_ignored();
    idle(); load_we = 1; load_addr = 8'd0; load_data = 32'hdead_beef;
    tick();
    idle();
    n_checks++; if (load_count !== 9'd2 || load_busy !== 1'b0) begin n_fail++; $display("FAIL run_we_count: got %0d busy=%b want 2 busy=0", load_count, load_busy); end
    do_fetch(32'h0);
    n_checks++; if (instruction !== 32'h201c_0000) begin n_fail++; $display("FAIL run_we_ram: got %h want 201c0000", instruction); end
  endtask

  task automatic test_stall();
    logic [31:0] addrs [3];
    addrs[0] = 32'h0; addrs[1] = 32'h6; addrs[2] = 32'h400;
    do_fetch(32'h4);
    for (int i = 0; i < 3; i++) begin
      idle(); fetch_stall = 1; fetch_req = 1; fetch_addr = addrs[i];
      tick();
      n_checks++; if (instruction !== 32'h2008_0040 || inst_valid !== 1'b1 || inst_fault !== 1'b0) begin n_fail++; $display("FAIL stall_hold%0d: got %h v=%b f=%b want 20080040 v=1 f=0", i, instruction, inst_valid, inst_fault); end
    end
    do_fetch(32'h6);
    idle(); fetch_stall = 1; fetch_addr = 32'h0; fetch_req = 1;
    tick();
    n_checks++; if (inst_fault !== 1'b1 || instruction !== 32'h0) begin n_fail++; $display("FAIL stall_fault_hold: got f=%b %h want f=1 00000000", inst_fault, instruction); end
    idle();
  endtask

  task automatic test_start_commit_same();
    idle(); load_start = 1; load_commit = 1;
    tick();
    n_checks++; if (load_busy !== 1'b1 || dbg_state_o !== 1'b1) begin n_fail++; $display("FAIL startcommit_run: got busy=%b want 1", load_busy); end
    idle(); load_start = 1; load_commit = 1;
    tick();
    n_checks++; if (load_busy !== 1'b1 || load_count !== 9'd0) begin n_fail++; $display("FAIL startcommit_load: got busy=%b cnt=%0d want 1 0", load_busy, load_count); end
    idle(); load_commit = 1;
    tick();
    idle();
    n_checks++; if (load_busy !== 1'b0) begin n_fail++; $display("FAIL commit_run: got %b want 0", load_busy); end
  endtask

  task automatic test_saturation();
    logic [31:0] exp_sum;
    logic [31:0] d;
    exp_sum = '0;
    do_start();
    for (int i = 0; i < 257; i++) begin
      d = i * 3 + 1;
      exp_sum ^= d;
      do_write(i[7:0], d, 1'b0);
      if (i == 255) begin
        n_checks++; if (load_count !== 9'd256) begin n_fail++; $display("FAIL sat_full: got %0d want 256", load_count); end
      end
    end
    n_checks++; if (load_count !== 9'd256) begin n_fail++; $display("FAIL sat_hold: got %0d want 256", load_count); end
    n_checks++; if (load_sum !== exp_sum) begin n_fail++; $display("FAIL sat_sum: got %h want %h", load_sum, exp_sum); end
    idle(); load_commit = 1;
    tick();
    do_fetch(32'h8);
    n_checks++; if (instruction !== 32'h7) begin n_fail++; $display("FAIL sat_fetch8: got %h want 00000007", instruction); end
    do_fetch(32'h3fc);
    n_checks++; if (instruction !== 32'h0000_02fe) begin n_fail++; $display("FAIL sat_fetch_top: got %h want 000002fe", instruction); end
  endtask

  task automatic test_reset_mid_load();
    do_start();
    do_write(8'd5, 32'h1234_5678, 1'b0);
    n_checks++; if (load_count !== 9'd1) begin n_fail++; $display("FAIL midload_count: got %0d want 1", load_count); end
    #2 reset = 0;
    #1;
    n_checks++; if (load_busy !== 1'b0 || load_count !== 9'd0 || load_sum !== 32'h0) begin n_fail++; $display("FAIL midload_reset: got busy=%b cnt=%0d sum=%h want 0 0 0", load_busy, load_count, load_sum); end
    tick();
    reset = 1;
    tick();
    do_fetch(32'h14);
    n_checks++; if (instruction !== 32'h1234_5678) begin n_fail++; $display("FAIL midload_kept: got %h want 12345678", instruction); end
  endtask

  // Test sequence and final report
  initial begin
    n_checks = 0;
    n_fail = 0;
    reset = 1;
    idle();
    #1;
    test_reset();
    test_boot_image();
    test_fault();
    test_bubble();
    test_load();
    test_run_write_ignored();
    test_stall();
    test_start_commit_same();
    test_saturation();
    test_reset_mid_load();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
